pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the RV32I five-stage core. It generates the stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards, squashes wrong-path instructions on a taken branch, and handles traps. It also holds the pipeline during data-memory wait states, with a timeout that raises a bus error. It sits beside the ID/EX register, whose flush input it drives to insert bubbles.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    ERR        = 2'd2,
    TRAP_FLUSH = 2'd3
  } state_t;

  localparam int DEF_TIMEOUT   = 16;
  localparam int DEF_TRAP_HOLD = 1;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_sel_trap;
    logic bus_err;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller, grouped for port hookup.
interface pipe_hazard_ctrl_if;

  logic [4:0] id_rs1_addr_in;
  logic [4:0] id_rs2_addr_in;
  logic       id_rs1_used_in;
  logic       id_rs2_used_in;
  logic       ex_load_in;
  logic [4:0] ex_rd_addr_in;
  logic       branch_taken_in;
  logic       trap_in;
  logic       dmem_req_in;
  logic       dmem_ack_in;

  logic       pc_stall_out;
  logic       ifid_stall_out;
  logic       idex_stall_out;
  logic       exmem_stall_out;
  logic       ifid_flush_out;
  logic       idex_flush_out;
  logic       exmem_flush_out;
  logic       pc_sel_trap_out;
  logic       bus_err_out;
  logic [31:0] stall_cnt_out;

  modport master (
    output id_rs1_addr_in, id_rs2_addr_in, id_rs1_used_in, id_rs2_used_in,
    output ex_load_in, ex_rd_addr_in, branch_taken_in, trap_in,
    output dmem_req_in, dmem_ack_in,
    input  pc_stall_out, ifid_stall_out, idex_stall_out, exmem_stall_out,
    input  ifid_flush_out, idex_flush_out, exmem_flush_out,
    input  pc_sel_trap_out, bus_err_out, stall_cnt_out
  );

  modport slave (
    input  id_rs1_addr_in, id_rs2_addr_in, id_rs1_used_in, id_rs2_used_in,
    input  ex_load_in, ex_rd_addr_in, branch_taken_in, trap_in,
    input  dmem_req_in, dmem_ack_in,
    output pc_stall_out, ifid_stall_out, idex_stall_out, exmem_stall_out,
    output ifid_flush_out, idex_flush_out, exmem_flush_out,
    output pc_sel_trap_out, bus_err_out, stall_cnt_out
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose rd feeds a used source in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rs1_addr,
  input  logic [4:0] i_rs2_addr,
  input  logic       i_rs1_used,
  input  logic       i_rs2_used,
  input  logic       i_ex_load,
  input  logic [4:0] i_ex_rd_addr,
  output logic       o_hazard
);

  logic [4:0] w_src_addr [2];
  logic [1:0] w_src_used;
  logic [1:0] w_src_hit;

  assign w_src_addr[0] = i_rs1_addr;
  assign w_src_addr[1] = i_rs2_addr;
  assign w_src_used    = {i_rs2_used, i_rs1_used};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign w_src_hit[gi] = w_src_used[gi] && (w_src_addr[gi] == i_ex_rd_addr);
    end
  endgenerate

  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign o_hazard = i_ex_load && (i_ex_rd_addr != REG_X0) && (|w_src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for PC, IF/ID, ID/EX and EX/MEM: load-use, branch, trap, dmem wait.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TRAP_HOLD = DEF_TRAP_HOLD
) (
  input logic               clk_in,
  input logic               rst_in,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = (TRAP_HOLD > 1) ? $clog2(TRAP_HOLD) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TRAP_HOLD - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_next;
  logic [31:0]       r_stall_cnt;
  ctrl_t             w_ctrl;
  logic              w_hazard;
  logic              w_mem_busy;

  load_use_detect u_load_use_detect (
    .i_rs1_addr   (bus.id_rs1_addr_in),
    .i_rs2_addr   (bus.id_rs2_addr_in),
    .i_rs1_used   (bus.id_rs1_used_in),
    .i_rs2_used   (bus.id_rs2_used_in),
    .i_ex_load    (bus.ex_load_in),
    .i_ex_rd_addr (bus.ex_rd_addr_in),
    .o_hazard     (w_hazard)
  );

  assign w_mem_busy = bus.dmem_req_in && !bus.dmem_ack_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  // r_wait_cnt holds the number of stall cycles already completed, so the
  // current cycle is the last permitted one when it equals TIMEOUT-1.
  always_comb begin
    w_ctrl       = CTRL_IDLE;
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    w_hold_next  = r_hold_cnt;
    if (rst_in) begin
      case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.ifid_stall  = 1'b1;
            w_ctrl.idex_stall  = 1'b1;
            w_ctrl.exmem_stall = 1'b1;
            w_state_next       = MEM_WAIT;
            w_wait_next        = WAIT_W'(1);
          end else if (bus.trap_in) begin
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
            w_ctrl.exmem_flush = 1'b1;
            w_ctrl.pc_sel_trap = 1'b1;
            w_state_next       = TRAP_FLUSH;
            w_hold_next        = '0;
          end else if (bus.branch_taken_in) begin
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
          end else if (w_hazard) begin
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.ifid_stall  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ack_in) begin
            w_state_next = RUN;
          end else begin
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.ifid_stall  = 1'b1;
            w_ctrl.idex_stall  = 1'b1;
            w_ctrl.exmem_stall = 1'b1;
            if (r_wait_cnt == WAIT_LAST) begin
              w_state_next = ERR;
            end else begin
              w_wait_next = r_wait_cnt + WAIT_W'(1);
            end
          end
        end
        ERR: begin
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_flush  = 1'b1;
          w_ctrl.exmem_flush = 1'b1;
          w_ctrl.pc_sel_trap = 1'b1;
          w_ctrl.bus_err     = 1'b1;
          w_state_next       = TRAP_FLUSH;
          w_hold_next        = '0;
        end
        TRAP_FLUSH: begin
          w_ctrl.ifid_flush = 1'b1;
          w_ctrl.idex_flush = 1'b1;
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_next = RUN;
          end else begin
            w_hold_next = r_hold_cnt + HOLD_W'(1);
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_stall_cnt <= '0;
    end else if (w_ctrl.pc_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.pc_stall_out    = w_ctrl.pc_stall;
  assign bus.ifid_stall_out  = w_ctrl.ifid_stall;
  assign bus.idex_stall_out  = w_ctrl.idex_stall;
  assign bus.exmem_stall_out = w_ctrl.exmem_stall;
  assign bus.ifid_flush_out  = w_ctrl.ifid_flush;
  assign bus.idex_flush_out  = w_ctrl.idex_flush;
  assign bus.exmem_flush_out = w_ctrl.exmem_flush;
  assign bus.pc_sel_trap_out = w_ctrl.pc_sel_trap;
  assign bus.bus_err_out     = w_ctrl.bus_err;
  assign bus.stall_cnt_out   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with TIMEOUT=4 and TRAP_HOLD=2.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  // Expected control vector: {pc,ifid,idex,exmem stalls, ifid,idex,exmem flushes, pc_sel_trap, bus_err}
  localparam logic [8:0] E_NONE  = 9'b0000_000_0_0;
  localparam logic [8:0] E_ALLST = 9'b1111_000_0_0;
  localparam logic [8:0] E_LU    = 9'b1100_010_0_0;
  localparam logic [8:0] E_BR    = 9'b0000_110_0_0;
  localparam logic [8:0] E_TF    = 9'b0000_110_0_0;
  localparam logic [8:0] E_TRAP  = 9'b0000_111_1_0;
  localparam logic [8:0] E_ERR   = 9'b0000_111_1_1;

  typedef struct {
    string       tag;
    logic [8:0]  outs;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_cnt;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if u_if ();

  pipe_hazard_ctrl #(
    .TIMEOUT   (4),
    .TRAP_HOLD (2)
  ) u_dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (u_if.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2,
                      input logic ld, input logic [4:0] rd,
                      input logic br, input logic trap,
                      input logic req, input logic ack,
                      input logic [8:0] eo);
    exp_t       e;
    logic [8:0] got;
    @(negedge clk);
    rst_n                = rst;
    u_if.id_rs1_addr_in  = rs1;
    u_if.id_rs2_addr_in  = rs2;
    u_if.id_rs1_used_in  = u1;
    u_if.id_rs2_used_in  = u2;
    u_if.ex_load_in      = ld;
    u_if.ex_rd_addr_in   = rd;
    u_if.branch_taken_in = br;
    u_if.trap_in         = trap;
    u_if.dmem_req_in     = req;
    u_if.dmem_ack_in     = ack;
    sb_q.push_back('{tag: tag, outs: eo, cnt: model_cnt});
    model_cnt = !rst ? 32'd0 : model_cnt + {31'd0, eo[8]};
    #1;
    e = sb_q.pop_front();
    got = {u_if.pc_stall_out, u_if.ifid_stall_out, u_if.idex_stall_out, u_if.exmem_stall_out,
           u_if.ifid_flush_out, u_if.idex_flush_out, u_if.exmem_flush_out,
           u_if.pc_sel_trap_out, u_if.bus_err_out};
    check_val({e.tag, ".ctrl"}, {23'd0, got}, {23'd0, e.outs});
    check_val({e.tag, ".cnt"}, u_if.stall_cnt_out, e.cnt);
    $display("step %-14s ctrl=%b exp=%b cnt=%0d exp=%0d", e.tag, got, e.outs,
             u_if.stall_cnt_out, e.cnt);
  endtask

  initial begin
    rst_n                = 1'b0;
    u_if.id_rs1_addr_in  = '0;
    u_if.id_rs2_addr_in  = '0;
    u_if.id_rs1_used_in  = 1'b0;
    u_if.id_rs2_used_in  = 1'b0;
    u_if.ex_load_in      = 1'b0;
    u_if.ex_rd_addr_in   = '0;
    u_if.branch_taken_in = 1'b0;
    u_if.trap_in         = 1'b0;
    u_if.dmem_req_in     = 1'b0;
    u_if.dmem_ack_in     = 1'b0;
    @(negedge clk);
    @(posedge clk);
    model_cnt = 32'd0;

    //    tag            rst rs1 rs2 u1 u2 ld rd br tr rq ak expected
    step("rst_forced",   0,  5,  0,  1, 0, 1, 5, 1, 1, 1, 0, E_NONE);
    step("lu_rs1",       1,  5,  0,  1, 0, 1, 5, 0, 0, 0, 0, E_LU);
    step("idle0",        1,  5,  0,  1, 0, 0, 5, 0, 0, 0, 0, E_NONE);
    step("lu_x0",        1,  0,  0,  1, 1, 1, 0, 0, 0, 0, 0, E_NONE);
    step("lu_rs2",       1,  3,  9,  1, 1, 1, 9, 0, 0, 0, 0, E_LU);
    step("lu_rs2_unused",1,  3,  9,  1, 0, 1, 9, 0, 0, 0, 0, E_NONE);
    step("br_over_lu",   1,  7,  0,  1, 0, 1, 7, 1, 0, 0, 0, E_BR);

    step("mw_c1",        1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("mw_c2_trap",   1,  0,  0,  0, 0, 0, 0, 1, 1, 1, 0, E_ALLST);
    step("mw_c3",        1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("mw_ack_c4",    1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 1, E_NONE);
    step("mw_after",     1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, E_NONE);

    step("to_c1",        1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("to_c2",        1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("to_c3",        1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("to_c4",        1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("to_err",       1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ERR);
    step("to_tf1",       1,  0,  0,  0, 0, 0, 0, 0, 1, 1, 0, E_TF);
    step("to_tf2",       1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, E_TF);
    step("to_run",       1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, E_NONE);

    step("trap_c0",      1,  4,  0,  1, 0, 1, 4, 1, 1, 0, 0, E_TRAP);
    step("trap_c1",      1,  4,  0,  1, 0, 1, 4, 0, 0, 0, 0, E_TF);
    step("trap_c2",      1,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, E_TF);
    step("trap_done",    1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, E_NONE);

    step("mem_over_trap",1,  0,  0,  0, 0, 0, 0, 1, 1, 1, 0, E_ALLST);
    step("mem_ack",      1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 1, E_NONE);

    step("rs_c1",        1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("rs_c2",        1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("rs_reset",     0,  0,  0,  0, 0, 0, 0, 0, 1, 1, 0, E_NONE);
    step("rs_idle",      1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
    step("rs_idle2",     1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
    step("rs_newreq",    1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, E_ALLST);
    step("rs_ack",       1,  0,  0,  0, 0, 0, 0, 0, 0, 1, 1, E_NONE);
    step("final",        1,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, E_NONE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
